// File: rtl/rob_port_sched.sv
// rob_port_sched: time-slotted write-port scheduler for a reorder buffer.
// A double-rate clock alternates between a decode slot (allocate at tail)
// and an execute slot (round-robin write-back from two execute units).
// Both ROB write ports are registered, and each port is only used in its
// own slot, so the two never write in the same cycle.
module rob_port_sched #(
  parameter int ADDR = 7,
  parameter int DW   = 114
) (
  input  logic            clk_2,
  input  logic            rstn,
  // decode allocation
  input  logic            dec_valid,
  input  logic [DW-1:0]   dec_data,
  output logic            dec_ready,
  // execute write-back, unit 0
  input  logic            ex0_valid,
  input  logic [ADDR-1:0] ex0_addr,
  input  logic [DW-1:0]   ex0_data,
  output logic            ex0_ready,
  // execute write-back, unit 1
  input  logic            ex1_valid,
  input  logic [ADDR-1:0] ex1_addr,
  input  logic [DW-1:0]   ex1_data,
  output logic            ex1_ready,
  // retirement / recovery
  input  logic            commit,
  input  logic            flush,
  // slot indicator
  output logic            phase,
  // registered decode write port
  output logic            rob_we_d,
  output logic [ADDR-1:0] rob_wa_d,
  output logic [DW-1:0]   rob_wd_d,
  // registered execute write port
  output logic            rob_we_e,
  output logic [ADDR-1:0] rob_wa_e,
  output logic [DW-1:0]   rob_wd_e,
  // occupancy
  output logic [ADDR-1:0] alloc_tag,
  output logic [ADDR:0]   count,
  output logic            full,
  output logic            empty
);

  typedef enum logic {
    PH_DEC = 1'b0,
    PH_EXE = 1'b1
  } phase_e;

  // Occupancy value meaning every entry is in use (2^ADDR).
  localparam logic [ADDR:0] FULL_CNT = {1'b1, {ADDR{1'b0}}};

  phase_e          phase_q,  phase_d;
  logic            rr_q,     rr_d;
  logic [ADDR-1:0] tail_q,   tail_d;
  logic [ADDR:0]   count_q,  count_d;
  logic            dp_we_q,  dp_we_d;
  logic [ADDR-1:0] dp_wa_q,  dp_wa_d;
  logic [DW-1:0]   dp_wd_q,  dp_wd_d;
  logic            ep_we_q,  ep_we_d;
  logic [ADDR-1:0] ep_wa_q,  ep_wa_d;
  logic [DW-1:0]   ep_wd_q,  ep_wd_d;

  logic gnt0, gnt1;
  logic dec_xfer, ex_xfer, commit_eff;

  // Slot-qualified handshakes: round-robin grant, then gate by slot,
  // occupancy and flush.
  always_comb begin
    // rr names the unit with priority; the other wins only when rr is idle.
    gnt0       = ex0_valid & (~rr_q | ~ex1_valid);
    gnt1       = ex1_valid & ( rr_q | ~ex0_valid);
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    dec_ready  = (phase_q == PH_DEC) & ~full  & ~flush;
    ex0_ready  = (phase_q == PH_EXE) & gnt0 & ~empty & ~flush;
    ex1_ready  = (phase_q == PH_EXE) & gnt1 & ~empty & ~flush;
    dec_xfer   = dec_valid & dec_ready;
    ex_xfer    = (ex0_valid & ex0_ready) | (ex1_valid & ex1_ready);
    // Retiring from an empty ROB has no effect.
    commit_eff = commit & ~empty;
  end

  // Next-state: slot toggle, tail/count bookkeeping and port load values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    phase_d = (phase_q == PH_DEC) ? PH_EXE : PH_DEC;
    rr_d    = rr_q;
    tail_d  = tail_q;
    count_d = count_q;
    dp_we_d = 1'b0;
    dp_wa_d = dp_wa_q;
    dp_wd_d = dp_wd_q;
    ep_we_d = 1'b0;
    ep_wa_d = ep_wa_q;
    ep_wd_d = ep_wd_q;

    if (flush) begin
      // Flush empties the ROB; the slot and arbitration pointer keep running.
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (dec_xfer) begin
        dp_we_d = 1'b1;
        dp_wa_d = tail_q;
        dp_wd_d = dec_data;
        tail_d  = tail_q + 1'b1;
      end

      if (ex_xfer) begin
        ep_we_d = 1'b1;
        if (ex0_ready) begin
          ep_wa_d = ex0_addr;
          ep_wd_d = ex0_data;
          rr_d    = 1'b1;
        end else begin
          ep_wa_d = ex1_addr;
          ep_wd_d = ex1_data;
          rr_d    = 1'b0;
        end
      end

      if (dec_xfer && !commit_eff) begin
        count_d = count_q + 1'b1;
      end else if (!dec_xfer && commit_eff) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_2) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      phase_q <= PH_DEC;
      rr_q    <= 1'b0;
      tail_q  <= '0;
      count_q <= '0;
      dp_we_q <= 1'b0;
      dp_wa_q <= '0;
      dp_wd_q <= '0;
      ep_we_q <= 1'b0;
      ep_wa_q <= '0;
      ep_wd_q <= '0;
    end else begin
      phase_q <= phase_d;
      rr_q    <= rr_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dp_we_q <= dp_we_d;
      dp_wa_q <= dp_wa_d;
      dp_wd_q <= dp_wd_d;
      ep_we_q <= ep_we_d;
      ep_wa_q <= ep_wa_d;
      ep_wd_q <= ep_wd_d;
    end
  end

  assign phase     = phase_q;
  assign alloc_tag = tail_q;
  assign count     = count_q;
  assign rob_we_d  = dp_we_q;
  assign rob_wa_d  = dp_wa_q;
  assign rob_wd_d  = dp_wd_q;
  assign rob_we_e  = ep_we_q;
  assign rob_wa_e  = ep_wa_q;
  assign rob_wd_e  = ep_wd_q;

endmodule

// File: tb/tb_rob_port_sched.sv
// tb_rob_port_sched: directed scenarios plus a randomized run, all compared
// against a behavioural model of the scheduler kept in plain integers.
module tb_rob_port_sched;

  localparam int ADDR  = 7;
  localparam int DW    = 114;
  localparam int DEPTH = 1 << ADDR;
  localparam int CW    = ADDR + 1;

  logic            clk_2 = 1'b0;
  logic            rstn;
  logic            dec_valid;
  logic [DW-1:0]   dec_data;
  logic            dec_ready;
  logic            ex0_valid, ex1_valid;
  logic [ADDR-1:0] ex0_addr,  ex1_addr;
  logic [DW-1:0]   ex0_data,  ex1_data;
  logic            ex0_ready, ex1_ready;
  logic            commit, flush;
  logic            phase;
  logic            rob_we_d, rob_we_e;
  logic [ADDR-1:0] rob_wa_d, rob_wa_e;
  logic [DW-1:0]   rob_wd_d, rob_wd_e;
  logic [ADDR-1:0] alloc_tag;
  logic [ADDR:0]   count;
  logic            full, empty;

  int n_checks = 0;
  int n_errors = 0;

  rob_port_sched #(.ADDR(ADDR), .DW(DW)) dut (
    .clk_2(clk_2), .rstn(rstn),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .ex0_valid(ex0_valid), .ex0_addr(ex0_addr), .ex0_data(ex0_data), .ex0_ready(ex0_ready),
    .ex1_valid(ex1_valid), .ex1_addr(ex1_addr), .ex1_data(ex1_data), .ex1_ready(ex1_ready),
    .commit(commit), .flush(flush), .phase(phase),
    .rob_we_d(rob_we_d), .rob_wa_d(rob_wa_d), .rob_wd_d(rob_wd_d),
    .rob_we_e(rob_we_e), .rob_wa_e(rob_wa_e), .rob_wd_e(rob_wd_e),
    .alloc_tag(alloc_tag), .count(count), .full(full), .empty(empty)
  );

  always #5 clk_2 = ~clk_2;

  // ---------------- behavioural reference model ----------------
  int            m_phase, m_rr, m_tail, m_count;
  bit            m_we_d, m_we_e;
  int            m_wa_d, m_wa_e;
  logic [DW-1:0] m_wd_d, m_wd_e;

  // Which execute unit wins this cycle: -1 none, else 0 or 1.
  function automatic int grant_of();
    if (m_rr == 0) return ex0_valid ? 0 : (ex1_valid ? 1 : -1);
    else           return ex1_valid ? 1 : (ex0_valid ? 0 : -1);
  endfunction

  function automatic bit exp_dec_ready();
    return (m_phase == 0) && (m_count < DEPTH) && !flush;
  endfunction

  function automatic bit exp_ex_ready(int n);
    return (m_phase == 1) && (grant_of() == n) && (m_count != 0) && !flush;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    int g;
    bit dx, ex, ce;
    if (!rstn) begin
      m_phase = 0; m_rr = 0; m_tail = 0; m_count = 0;
      m_we_d = 0; m_we_e = 0; m_wa_d = 0; m_wa_e = 0;
      m_wd_d = '0; m_wd_e = '0;
    end else begin
      g  = grant_of();
      dx = dec_valid && exp_dec_ready();
      ex = (g >= 0) && exp_ex_ready(g);
      ce = commit && (m_count > 0);
      if (flush) begin
        m_count = 0; m_tail = 0; m_we_d = 0; m_we_e = 0;
      end else begin
        m_we_d = dx;
        if (dx) begin
          m_wa_d = m_tail;
          m_wd_d = dec_data;
          m_tail = (m_tail + 1) % DEPTH;
        end
        m_we_e = ex;
        if (ex) begin
          m_wa_e = (g == 0) ? int'(ex0_addr) : int'(ex1_addr);
          m_wd_e = (g == 0) ? ex0_data : ex1_data;
          m_rr   = 1 - g;
        end
        if (dx && !ce)      m_count = m_count + 1;
        else if (!dx && ce) m_count = m_count - 1;
      end
      m_phase = 1 - m_phase;
    end
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_data = '0;
    ex0_valid = 0; ex0_addr = '0; ex0_data = '0;
    ex1_valid = 0; ex1_addr = '0; ex1_data = '0;
    commit = 0; flush = 0;
  endtask

  task automatic do_reset();
    rstn = 0;
    idle_inputs();
    tick();
    tick();
    rstn = 1;
  endtask

  // Allocate n entries, presenting requests only in decode slots.
  task automatic decode_n(int n);
    int got;
    got = 0;
    for (int c = 0; c < 2 * n + 4 && got < n; c++) begin
      dec_valid = (m_phase == 0);
      dec_data  = rand_data();
      tick();
      if (m_we_d) got++;
    end
    dec_valid = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({phase, count, full, empty, alloc_tag} !== {1'b0, CW'(0), 1'b0, 1'b1, ADDR'(0)}) begin
      n_errors++;
      $display("FAIL reset_status: got phase=%0b count=%0d full=%0b empty=%0b tag=%0d, want 0,0,0,1,0",
               phase, count, full, empty, alloc_tag);
    end
    n_checks++;
    if ({rob_we_d, rob_we_e, rob_wa_d, rob_wa_e} !== '0 || rob_wd_d !== '0 || rob_wd_e !== '0) begin
      n_errors++;
      $display("FAIL reset_ports: got we_d=%0b we_e=%0b wa_d=%0d wa_e=%0d, want all zero",
               rob_we_d, rob_we_e, rob_wa_d, rob_wa_e);
    end
    rstn = 1;
  endtask

  task automatic test_fill();
    int k;
    bit slot0;
    logic [DW-1:0] kd;
    do_reset();
    k = 0;
    dec_valid = 1;
    for (int cyc = 0; cyc < 2 * DEPTH + 8 && m_count < DEPTH; cyc++) begin
      kd = DW'(k);
      dec_data = kd;
      #1;
      slot0 = (m_phase == 0);
      n_checks++;
      if (dec_ready !== slot0) begin
        n_errors++;
        $display("FAIL fill_ready: cycle %0d got %0b want %0b", cyc, dec_ready, slot0);
      end
      tick();
      n_checks++;
      if (slot0) begin
        if (rob_we_d !== 1'b1 || rob_wa_d !== ADDR'(k) || rob_wd_d !== kd) begin
          n_errors++;
          $display("FAIL fill_write: got we=%0b wa=%0d wd=%0h want 1,%0d,%0h",
                   rob_we_d, rob_wa_d, rob_wd_d, k, kd);
        end
        k++;
      end else if (rob_we_d !== 1'b0) begin
        n_errors++;
        $display("FAIL fill_idle_we: got %0b want 0", rob_we_d);
      end
    end
    n_checks++;
    if (count !== CW'(DEPTH) || full !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_full: got count=%0d full=%0b want %0d,1", count, full, DEPTH);
    end
    n_checks++;
    if (rob_wa_d !== ADDR'(DEPTH - 1) || alloc_tag !== ADDR'(0)) begin
      n_errors++;
      $display("FAIL tail_wrap: got wa_d=%0d tag=%0d want %0d,0", rob_wa_d, alloc_tag, DEPTH - 1);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (dec_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL full_ready: got %0b want 0", dec_ready);
      end
      tick();
    end
    n_checks++;
    if (count !== CW'(DEPTH) || rob_we_d !== 1'b0) begin
      n_errors++;
      $display("FAIL full_hold: got count=%0d we_d=%0b want %0d,0", count, rob_we_d, DEPTH);
    end
    idle_inputs();
  endtask

  task automatic test_exec_rr();
    int seq [3] = '{0, 1, 0};
    int j;
    logic [DW-1:0] d0, d1;
    do_reset();
    decode_n(3);
    d0 = rand_data();
    d1 = rand_data();
    ex0_valid = 1; ex0_addr = 7'd11; ex0_data = d0;
    ex1_valid = 1; ex1_addr = 7'd22; ex1_data = d1;
    j = 0;
    for (int c = 0; c < 10 && j < 3; c++) begin
      #1;
      n_checks++;
      if (m_phase == 1) begin
        if (ex0_ready !== (seq[j] == 0) || ex1_ready !== (seq[j] == 1)) begin
          n_errors++;
          $display("FAIL rr_ready: grant %0d got r0=%0b r1=%0b want unit %0d", j, ex0_ready, ex1_ready, seq[j]);
        end
        tick();
        n_checks++;
        if (rob_we_e !== 1'b1 || rob_wa_e !== (seq[j] == 0 ? 7'd11 : 7'd22) ||
            rob_wd_e !== (seq[j] == 0 ? d0 : d1)) begin
          n_errors++;
          $display("FAIL rr_write: grant %0d got we=%0b wa=%0d want unit %0d", j, rob_we_e, rob_wa_e, seq[j]);
        end
        j++;
      end else begin
        if (ex0_ready !== 1'b0 || ex1_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL rr_slot0: got r0=%0b r1=%0b want 0,0", ex0_ready, ex1_ready);
        end
        tick();
      end
    end
    n_checks++;
    if (j != 3 || count !== CW'(3)) begin
      n_errors++;
      $display("FAIL rr_done: got grants=%0d count=%0d want 3,3", j, count);
    end
    idle_inputs();
  endtask

  task automatic test_dec_commit();
    do_reset();
    decode_n(5);
    if (m_phase != 0) tick();
    dec_valid = 1; dec_data = rand_data(); commit = 1;
    #1;
    n_checks++;
    if (dec_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL dc_ready: got %0b want 1", dec_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (count !== CW'(5) || alloc_tag !== ADDR'(6) || rob_we_d !== 1'b1) begin
      n_errors++;
      $display("FAIL dec_commit: got count=%0d tag=%0d we_d=%0b want 5,6,1", count, alloc_tag, rob_we_d);
    end
    commit = 1;
    tick();
    commit = 0;
    n_checks++;
    if (count !== CW'(4)) begin
      n_errors++;
      $display("FAIL commit_only: got %0d want 4", count);
    end
  endtask

  task automatic test_flush();
    do_reset();
    decode_n(10);
    if (m_phase != 1) tick();
    flush = 1; ex0_valid = 1; ex0_addr = 7'd5; ex0_data = rand_data();
    #1;
    n_checks++;
    if (ex0_ready !== 1'b0 || dec_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready: got ex0=%0b dec=%0b want 0,0", ex0_ready, dec_ready);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (count !== CW'(0) || alloc_tag !== ADDR'(0) || rob_we_e !== 1'b0 || empty !== 1'b1 || phase !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_state: got count=%0d tag=%0d we_e=%0b empty=%0b phase=%0b want 0,0,0,1,0",
               count, alloc_tag, rob_we_e, empty, phase);
    end
  endtask

  task automatic test_empty();
    do_reset();
    if (m_phase != 1) tick();
    ex1_valid = 1; ex1_addr = 7'd9; commit = 1;
    #1;
    n_checks++;
    if (ex1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_ready: got %0b want 0", ex1_ready);
    end
    tick();
    n_checks++;
    if (count !== CW'(0) || rob_we_e !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_commit: got count=%0d we_e=%0b want 0,0", count, rob_we_e);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit fill_phase;
      fill_phase = (c < 1200);
      dec_valid = fill_phase ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
      dec_data  = rand_data();
      ex0_valid = $urandom_range(0, 1) == 1; ex0_addr = ADDR'($urandom()); ex0_data = rand_data();
      ex1_valid = $urandom_range(0, 1) == 1; ex1_addr = ADDR'($urandom()); ex1_data = rand_data();
      commit    = fill_phase ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 3);
      flush     = !fill_phase && ($urandom_range(0, 199) == 0);
      rstn      = fill_phase || ($urandom_range(0, 499) != 0);
      #1;
      n_checks++;
      if ({dec_ready, ex0_ready, ex1_ready} !== {exp_dec_ready(), exp_ex_ready(0), exp_ex_ready(1)}) begin
        n_errors++;
        $display("FAIL rnd_ready: cycle %0d got %b%b%b want %b%b%b", c, dec_ready, ex0_ready, ex1_ready,
                 exp_dec_ready(), exp_ex_ready(0), exp_ex_ready(1));
      end
      n_checks++;
      if ({count, alloc_tag, phase, full, empty} !==
          {CW'(m_count), ADDR'(m_tail), m_phase[0], m_count == DEPTH, m_count == 0}) begin
        n_errors++;
        $display("FAIL rnd_status: cycle %0d got count=%0d tag=%0d phase=%0b want %0d,%0d,%0d",
                 c, count, alloc_tag, phase, m_count, m_tail, m_phase);
      end
      n_checks++;
      if ({rob_we_d, rob_wa_d, rob_wd_d} !== {m_we_d, ADDR'(m_wa_d), m_wd_d}) begin
        n_errors++;
        $display("FAIL rnd_dport: cycle %0d got we=%0b wa=%0d want %0b,%0d", c, rob_we_d, rob_wa_d, m_we_d, m_wa_d);
      end
      n_checks++;
      if ({rob_we_e, rob_wa_e, rob_wd_e} !== {m_we_e, ADDR'(m_wa_e), m_wd_e}) begin
        n_errors++;
        $display("FAIL rnd_eport: cycle %0d got we=%0b wa=%0d want %0b,%0d", c, rob_we_e, rob_wa_e, m_we_e, m_wa_e);
      end
      n_checks++;
      if ((rob_we_d & rob_we_e) !== 1'b0) begin
        n_errors++;
        $display("FAIL rnd_port_overlap: cycle %0d got both write enables, want at most one", c);
      end
      tick();
    end
    rstn = 1;
    idle_inputs();
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    test_reset();
    test_fill();
    test_exec_rr();
    test_dec_commit();
    test_flush();
    test_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
